// File: rtl/kgp_pkg.sv
// Shared definitions for the KGP-RISC sequencer: branch codes, FSM states,
// instruction width and the sequential PC step.
package kgp_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_INC  = 4;

    typedef enum logic [3:0] {
        BR_NONE = 4'd0,
        BR_B    = 4'd1,
        BR_BL   = 4'd2,
        BR_BCY  = 4'd3,
        BR_BNCY = 4'd4,
        BR_BR   = 4'd5,
        BR_BLTZ = 4'd6,
        BR_BZ   = 4'd7,
        BR_BNZ  = 4'd8
    } br_op_e;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

endpackage

// File: rtl/kgp_seq_ctrl_branch_resolve.sv
// Branch condition evaluation: decides whether the decoded branch is taken
// from the branch code, the architectural carry and the live ALU flags.
module kgp_branch_resolve
    import kgp_pkg::*;
(
    input  logic [3:0] branch_op,
    input  logic       carry_q,
    input  logic       flag_zero,
    input  logic       flag_neg,
    output logic       taken
);

    // Map each branch code onto its condition; unknown codes never branch.
    always_comb begin
        taken = 1'b0;
        case (branch_op)
            BR_B, BR_BL, BR_BR: taken = 1'b1;
            BR_BCY:             taken = carry_q;
            BR_BNCY:            taken = ~carry_q;
            BR_BLTZ:            taken = flag_neg;
            BR_BZ:              taken = flag_zero;
            BR_BNZ:             taken = ~flag_zero;
            default:            taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/kgp_seq_ctrl.sv
// Multi-cycle instruction sequencer: walks FETCH/DECODE/EXEC/MEM/WB over
// variable-latency memory handshakes, owns the PC, the carry flag and the
// retired-instruction counter, and drives registered datapath strobes.
module kgp_seq_ctrl
    import kgp_pkg::*;
#(
    parameter int unsigned     PC_W     = 32,
    parameter int unsigned     CNT_W    = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
)(
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] ir,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic               reg_write,
    input  logic [3:0]         branch_op,
    input  logic               halt_op,
    input  logic               flag_carry,
    input  logic               flag_zero,
    input  logic               flag_neg,
    input  logic [PC_W-1:0]    branch_target,
    output logic               alu_en,
    output logic               dmem_req,
    output logic               dmem_we,
    input  logic               dmem_ack,
    output logic               reg_we,
    output logic               link_we,
    output logic [PC_W-1:0]    pc,
    output logic               carry_q,
    output logic               halted,
    output logic [CNT_W-1:0]   retired
);

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               carry_flag_q, carry_flag_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               imem_req_q, imem_req_d;
    logic               dmem_req_q, dmem_req_d;
    logic               dmem_we_q, dmem_we_d;
    logic               alu_en_q, alu_en_d;
    logic               reg_we_q, reg_we_d;
    logic               link_we_q, link_we_d;
    logic               halted_q, halted_d;
    logic               retire;
    logic               taken;

    kgp_branch_resolve u_branch_resolve (
        .branch_op (branch_op),
        .carry_q   (carry_flag_q),
        .flag_zero (flag_zero),
        .flag_neg  (flag_neg),
        .taken     (taken)
    );

    // Next-state, architectural updates and next strobe values.
    // Strobes are derived from the next state so every output is a flop;
    // the first FETCH after reset therefore has a one-cycle request bubble,
    // and an ack is only honoured while the request is actually up.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        carry_flag_d = carry_flag_q;
        retired_d    = retired_q;
        retire       = 1'b0;

        case (state_q)
            ST_FETCH: begin
                if (imem_req_q && imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = halt_op ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                if (reg_write && (branch_op == BR_NONE)) begin
                    carry_flag_d = flag_carry;
                end
                pc_d = taken ? branch_target : (pc_q + PC_W'(PC_INC));
                if (branch_op != BR_NONE) begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end else if (mem_read || mem_write) begin
                    state_d = ST_MEM;
                end else if (reg_write) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    if (mem_read) begin
                        state_d = ST_WB;
                    end else begin
                        state_d = ST_FETCH;
                        retire  = 1'b1;
                    end
                end
            end
            ST_WB: begin
                state_d = ST_FETCH;
                retire  = 1'b1;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        if (retire && (retired_q != '1)) begin
            retired_d = retired_q + CNT_W'(1);
        end

        imem_req_d = (state_d == ST_FETCH);
        alu_en_d   = (state_d == ST_EXEC);
        link_we_d  = (state_d == ST_EXEC) && (branch_op == BR_BL);
        dmem_req_d = (state_d == ST_MEM);
        dmem_we_d  = (state_d == ST_MEM) && mem_write;
        reg_we_d   = (state_d == ST_WB);
        halted_d   = (state_d == ST_HALT);
    end

    // State register; synchronous reset overrides any in-flight handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            ir_q         <= '0;
            carry_flag_q <= 1'b0;
            retired_q    <= '0;
            imem_req_q   <= 1'b0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            alu_en_q     <= 1'b0;
            reg_we_q     <= 1'b0;
            link_we_q    <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            carry_flag_q <= carry_flag_d;
            retired_q    <= retired_d;
            imem_req_q   <= imem_req_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            alu_en_q     <= alu_en_d;
            reg_we_q     <= reg_we_d;
            link_we_q    <= link_we_d;
            halted_q     <= halted_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign ir        = ir_q;
    assign alu_en    = alu_en_q;
    assign dmem_req  = dmem_req_q;
    assign dmem_we   = dmem_we_q;
    assign reg_we    = reg_we_q;
    assign link_we   = link_we_q;
    assign pc        = pc_q;
    assign carry_q   = carry_flag_q;
    assign halted    = halted_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_kgp_seq_ctrl.sv
// Self-checking bench for kgp_seq_ctrl: per-instruction expectations are
// pushed to a scoreboard before the handshakes are driven and popped once
// the instruction has completed.
module tb_kgp_seq_ctrl;
    import kgp_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] ir;
    logic        mem_read = 1'b0, mem_write = 1'b0, reg_write = 1'b0;
    logic [3:0]  branch_op = '0;
    logic        halt_op = 1'b0;
    logic        flag_carry = 1'b0, flag_zero = 1'b0, flag_neg = 1'b0;
    logic [31:0] branch_target = '0;
    logic        alu_en, dmem_req, dmem_we;
    logic        dmem_ack = 1'b0;
    logic        reg_we, link_we;
    logic [31:0] pc;
    logic        carry_q, halted;
    logic [31:0] retired;

    kgp_seq_ctrl #(.PC_W(32), .CNT_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .ir(ir),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .branch_op(branch_op), .halt_op(halt_op),
        .flag_carry(flag_carry), .flag_zero(flag_zero), .flag_neg(flag_neg),
        .branch_target(branch_target),
        .alu_en(alu_en), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .reg_we(reg_we), .link_we(link_we), .pc(pc), .carry_q(carry_q),
        .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] ret;
        logic        carry;
        logic        halted;
        logic [31:0] ir;
        int          cycles;
        int          req;
        int          early;
        int          dreq;
        int          dwe;
        int          rwe;
        int          link;
        int          alu;
    } rec_t;

    typedef struct {
        logic       c;
        logic       z;
        logic       n;
        logic [3:0] op;
        logic       tk;
    } brv_t;

    rec_t        sb[$];
    brv_t        tbl[16];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_pc = '0, m_ret = '0;
    logic        m_carry = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One instruction: model update, scoreboard push, handshakes, pop and compare.
    task automatic run_instr(input string name, input logic rd, input logic wr, input logic rw,
                             input logic [3:0] bop, input logic hlt, input logic fc,
                             input logic fz, input logic fn, input logic [31:0] tgt,
                             input logic tk, input logic [31:0] word, input int iw, input int dw);
        rec_t e, o;
        logic [31:0] ir_start;
        int   iwc, dwc;
        bit   acked, done;
        logic is_mem;

        chk({name, ".addr"}, imem_addr, m_pc);
        is_mem   = (bop == 4'd0) && (rd || wr) && !hlt;
        e.name   = name;
        e.req    = iw + 1;
        e.early  = 0;
        e.ir     = word;
        e.halted = hlt;
        e.alu    = hlt ? 0 : 1;
        e.link   = (!hlt && bop == 4'd2) ? 1 : 0;
        e.dreq   = is_mem ? dw + 1 : 0;
        e.dwe    = (is_mem && wr) ? dw + 1 : 0;
        e.rwe    = (!hlt && bop == 4'd0 && (is_mem ? rd : rw)) ? 1 : 0;
        if (hlt) e.cycles = iw + 2;
        else if (is_mem) e.cycles = iw + 3 + dw + 1 + (rd ? 1 : 0);
        else e.cycles = iw + 3 + ((bop == 4'd0 && rw) ? 1 : 0);
        if (!hlt) begin
            m_pc = tk ? tgt : m_pc + 32'd4;
            if (rw && bop == 4'd0) m_carry = fc;
            if (m_ret != 32'hFFFF_FFFF) m_ret = m_ret + 32'd1;
        end
        e.pc = m_pc; e.ret = m_ret; e.carry = m_carry;
        sb.push_back(e);

        mem_read = rd; mem_write = wr; reg_write = rw; branch_op = bop; halt_op = hlt;
        flag_carry = fc; flag_zero = fz; flag_neg = fn; branch_target = tgt;
        o.cycles = 0; o.req = 0; o.early = 0; o.dreq = 0; o.dwe = 0; o.rwe = 0; o.link = 0; o.alu = 0;
        ir_start = ir; iwc = 0; dwc = 0; acked = 0; done = 0;
        for (int c = 0; c < 300; c++) begin
            if (acked && (imem_req || halted)) begin
                done = 1;
                break;
            end
            o.cycles++;
            if (imem_req) o.req++;
            if (dmem_req) begin
                o.dreq++;
                if (dmem_we) o.dwe++;
            end
            if (reg_we) o.rwe++;
            if (link_we) o.link++;
            if (alu_en) o.alu++;
            if (!acked && ir !== ir_start) o.early++;
            imem_ack = 1'b0;
            imem_rdata = 32'hBAD0_0000 | 32'(c);
            if (imem_req && !acked) begin
                if (iwc == iw) begin
                    imem_ack = 1'b1; imem_rdata = word; acked = 1;
                end else iwc++;
            end
            dmem_ack = 1'b0;
            if (dmem_req) begin
                if (dwc == dw) dmem_ack = 1'b1;
                else dwc++;
            end
            step();
        end
        imem_ack = 1'b0; dmem_ack = 1'b0;
        chk({name, ".completed"}, done, 1'b1);
        o.pc = pc; o.ret = retired; o.carry = carry_q; o.halted = halted; o.ir = ir;

        e = sb.pop_front();
        chk({e.name, ".pc"}, o.pc, e.pc);
        chk({e.name, ".retired"}, o.ret, e.ret);
        chk({e.name, ".carry_q"}, o.carry, e.carry);
        chk({e.name, ".halted"}, o.halted, e.halted);
        chk({e.name, ".ir"}, o.ir, e.ir);
        chk({e.name, ".cycles"}, o.cycles, e.cycles);
        chk({e.name, ".imem_req_cycles"}, o.req, e.req);
        chk({e.name, ".ir_early_change"}, o.early, e.early);
        chk({e.name, ".dmem_req_cycles"}, o.dreq, e.dreq);
        chk({e.name, ".dmem_we_cycles"}, o.dwe, e.dwe);
        chk({e.name, ".reg_we_pulses"}, o.rwe, e.rwe);
        chk({e.name, ".link_we_pulses"}, o.link, e.link);
        chk({e.name, ".alu_en_pulses"}, o.alu, e.alu);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   viol;
        logic [31:0] pc_h, ret_h;
        bit   reached;

        // carry, zero, neg, op, expected taken
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 4'd1, 1'b1};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 4'd2, 1'b1};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 4'd3, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 4'd4, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 4'd5, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 4'd6, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 4'd7, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 4'd8, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 4'd1, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 4'd2, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 4'd3, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 4'd4, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 4'd5, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 4'd6, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 4'd7, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 4'd8, 1'b1};

        // Reset state
        reset = 1'b1;
        repeat (3) step();
        chk("rst.pc", pc, 32'h0);
        chk("rst.ir", ir, 32'h0);
        chk("rst.carry_q", carry_q, 1'b0);
        chk("rst.retired", retired, 32'h0);
        chk("rst.halted", halted, 1'b0);
        chk("rst.strobes", {imem_req, dmem_req, dmem_we, alu_en, reg_we, link_we}, 6'b0);
        reset = 1'b0;
        step();
        chk("rst.first_fetch_req", imem_req, 1'b1);

        run_instr("addi0", 0, 0, 1, 4'd0, 0, 0, 0, 0, 32'h0, 0, 32'h1111_0001, 0, 0);
        run_instr("addi_wait3", 0, 0, 1, 4'd0, 0, 1, 0, 0, 32'h0, 0, 32'h1111_0002, 3, 0);
        run_instr("lw_wait2", 1, 0, 1, 4'd0, 0, 1, 0, 0, 32'h0, 0, 32'h2222_0003, 0, 2);
        run_instr("sw_wait1", 0, 1, 0, 4'd0, 0, 0, 0, 0, 32'h0, 0, 32'h3333_0004, 1, 1);
        run_instr("nop", 0, 0, 0, 4'd0, 0, 0, 0, 0, 32'h0, 0, 32'h4444_0005, 0, 0);

        // Branch sweep: set carry with an ALU op, then the branch under test.
        for (int i = 0; i < 16; i++) begin
            run_instr($sformatf("setc%0d", i), 0, 0, 1, 4'd0, 0, tbl[i].c, 0, 0, 32'h0, 0,
                      32'h5000_0000 | 32'(i), 0, 0);
            run_instr($sformatf("br%0d_op%0d", i, tbl[i].op), 0, 0, 0, tbl[i].op, 0, ~tbl[i].c,
                      tbl[i].z, tbl[i].n, 32'h100, tbl[i].tk, 32'h6000_0000 | 32'(i), 0, 0);
        end

        // PC wrap
        run_instr("b_top", 0, 0, 0, 4'd1, 0, 0, 0, 0, 32'hFFFF_FFFC, 1, 32'h7000_0001, 0, 0);
        run_instr("addi_wrap", 0, 0, 1, 4'd0, 0, 0, 0, 0, 32'h0, 0, 32'h7000_0002, 0, 0);

        // Reset arriving together with dmem_ack while in MEM
        mem_read = 1'b1; mem_write = 1'b0; reg_write = 1'b1; branch_op = 4'd0; halt_op = 1'b0;
        imem_rdata = 32'h8000_0001;
        reached = 0;
        for (int c = 0; c < 20; c++) begin
            if (dmem_req) begin
                reached = 1;
                break;
            end
            imem_ack = imem_req;
            step();
        end
        imem_ack = 1'b0;
        chk("mrst.reached_mem", reached, 1'b1);
        dmem_ack = 1'b1;
        reset = 1'b1;
        step();
        dmem_ack = 1'b0;
        chk("mrst.pc", pc, 32'h0);
        chk("mrst.dmem_req", dmem_req, 1'b0);
        chk("mrst.retired", retired, 32'h0);
        chk("mrst.reg_we", reg_we, 1'b0);
        chk("mrst.carry_q", carry_q, 1'b0);
        reset = 1'b0;
        m_pc = '0; m_ret = '0; m_carry = 1'b0;
        step();
        chk("mrst.fetch_req", imem_req, 1'b1);
        chk("mrst.fetch_addr", imem_addr, 32'h0);

        // Halt
        run_instr("addi_pre_halt", 0, 0, 1, 4'd0, 0, 0, 0, 0, 32'h0, 0, 32'h9000_0001, 0, 0);
        run_instr("halt", 0, 0, 0, 4'd0, 1, 0, 0, 0, 32'h0, 0, 32'h9000_0002, 0, 0);
        pc_h = pc; ret_h = retired;
        viol = 0;
        for (int c = 0; c < 20; c++) begin
            imem_ack = 1'b1;
            if (imem_req || dmem_req || !halted || pc !== pc_h || retired !== ret_h) viol++;
            step();
        end
        imem_ack = 1'b0;
        chk("halt.hold_violations", viol, 0);
        chk("halt.retired", retired, 32'd1);
        chk("sb.empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
